// File: rtl/stego_pkg.sv
// Shared types and constants for the stego embed/extract datapath.
package stego_pkg;

  localparam int unsigned LSBS_PER_WORD = 4;
  localparam int unsigned MSG_WIDTH     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_RD,
    S_WAIT,
    S_MOD,
    S_WR,
    S_REL,
    S_DONE
  } state_t;

endpackage

// File: rtl/stego_embed_ctrl_if.sv
// PL-side BRAM port A plus the message byte stream.
//   master: bram_mode, pl_addr, pl_din, pl_we, msg_ready out; pl_dout, msg_valid, msg_data in
//   slave : the mirror image (BRAM mux / message source side)
interface stego_embed_ctrl_if import stego_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTES  = 4
);

  logic                  bram_mode;
  logic [ADDR_WIDTH-1:0] pl_addr;
  logic [DATA_WIDTH-1:0] pl_din;
  logic [NUM_BYTES-1:0]  pl_we;
  logic [DATA_WIDTH-1:0] pl_dout;
  logic                  msg_valid;
  logic [MSG_WIDTH-1:0]  msg_data;
  logic                  msg_ready;

  modport master (
    output bram_mode, pl_addr, pl_din, pl_we, msg_ready,
    input  pl_dout, msg_valid, msg_data
  );

  modport slave (
    input  bram_mode, pl_addr, pl_din, pl_we, msg_ready,
    output pl_dout, msg_valid, msg_data
  );

endinterface

// File: rtl/lsb_embed.sv
// Replaces the LSB of each byte lane of a word with one bit of a nibble
// (lane i takes bits[i]); all other bits pass through.
//   word   : pixel word read from BRAM
//   bits   : one message bit per byte lane
//   result : modified word
module lsb_embed #(
  parameter int NUM_BYTES = 4
) (
  input  logic [8*NUM_BYTES-1:0] word,
  input  logic [NUM_BYTES-1:0]   bits,
  output logic [8*NUM_BYTES-1:0] result
);

  always_comb begin
    result = word;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      result[8*i] = bits[i];
    end
  end

endmodule

// File: rtl/stego_embed_ctrl.sv
// Borrows BRAM port A from the PS, embeds a message stream into the LSBs of
// num_words pixel words starting at base_addr, then hands the port back.
//   pl_clk/pl_rst_n : clock, async active-low reset
//   start/abort     : job launch pulse (IDLE only) / stop at next safe point
//   base_addr/num_words : job extent, sampled on start
//   busy/done/aborted/words_done : job status
//   bus             : BRAM port + message stream (master side)
module stego_embed_ctrl import stego_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTES  = LSBS_PER_WORD,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  pl_clk,
  input  logic                  pl_rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [REG_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [REG_WIDTH-1:0]  words_done,
  stego_embed_ctrl_if.master    bus
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0]  num_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_emb;
  logic [MSG_WIDTH-1:0]  msg_q;
  logic                  have_byte;
  logic                  abort_seen;
  logic                  need_byte;
  logic                  last_word;
  logic                  in_job;
  logic [NUM_BYTES-1:0]  nibble;

  // words_done doubles as the word index k while a job runs.
  always_comb begin
    need_byte = !words_done[0] && !have_byte;
    last_word = (words_done + REG_WIDTH'(1)) == num_q;
    nibble    = words_done[0] ? msg_q[MSG_WIDTH-1 -: NUM_BYTES] : msg_q[NUM_BYTES-1:0];
    in_job    = state inside {S_ACQ, S_RD, S_WAIT, S_MOD, S_WR};
  end

  lsb_embed #(
    .NUM_BYTES(NUM_BYTES)
  ) u_embed (
    .word   (word_q),
    .bits   (nibble),
    .result (word_emb)
  );

  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ACQ;
      S_ACQ:   state_nxt = (abort || num_q == '0) ? S_REL : S_RD;
      S_RD:    state_nxt = abort ? S_REL : S_WAIT;
      S_WAIT:  state_nxt = abort ? S_REL : S_MOD;
      S_MOD: begin
        if (abort) begin
          state_nxt = S_REL;
        end else if (!(need_byte && !bus.msg_valid)) begin
          state_nxt = S_WR;
        end
      end
      S_WR:    state_nxt = (abort || last_word) ? S_REL : S_RD;
      S_REL:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bram_mode covers ACQ..REL; REL releases it so DONE already sees 0.
  always_comb begin
    bus.bram_mode = 1'b0;
    bus.pl_we     = '0;
    bus.msg_ready = 1'b0;
    bus.pl_addr   = addr_q;
    bus.pl_din    = word_emb;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      S_ACQ, S_RD, S_WAIT, S_REL: begin
        bus.bram_mode = 1'b1;
        busy          = 1'b1;
      end
      S_MOD: begin
        bus.bram_mode = 1'b1;
        busy          = 1'b1;
        bus.msg_ready = need_byte && bus.msg_valid;
      end
      S_WR: begin
        bus.bram_mode = 1'b1;
        busy          = 1'b1;
        bus.pl_we     = '1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pl_clk or negedge pl_rst_n) begin
    if (!pl_rst_n) begin
      addr_q     <= '0;
      num_q      <= '0;
      word_q     <= '0;
      msg_q      <= '0;
      have_byte  <= 1'b0;
      abort_seen <= 1'b0;
      aborted    <= 1'b0;
      words_done <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            num_q      <= num_words;
            words_done <= '0;
            aborted    <= 1'b0;
            abort_seen <= 1'b0;
            have_byte  <= 1'b0;
          end
        end
        S_MOD: begin
          word_q <= bus.pl_dout;
          if (bus.msg_ready) begin
            msg_q     <= bus.msg_data;
            have_byte <= 1'b1;
          end
        end
        S_WR: begin
          words_done <= words_done + REG_WIDTH'(1);
          if (words_done[0]) have_byte <= 1'b0;
          if (!last_word && !abort) addr_q <= addr_q + ADDR_WIDTH'(NUM_BYTES);
        end
        S_REL:   aborted <= abort_seen;
        default: ;
      endcase
      if (in_job && abort) abort_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stego_embed_ctrl.sv
module tb_stego_embed_ctrl;

  logic        pl_clk    = 1'b0;
  logic        pl_rst_n  = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] num_words = '0;
  logic        busy, done, aborted;
  logic [31:0] words_done;

  stego_embed_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BYTES(4)) bus ();

  stego_embed_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BYTES(4), .REG_WIDTH(32)
  ) dut (
    .pl_clk     (pl_clk),
    .pl_rst_n   (pl_rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done),
    .bus        (bus)
  );

  always #5 pl_clk = ~pl_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // BRAM: registered read, byte-enable write.
  logic [31:0] mem [bit [31:0]];
  logic [31:0] wtmp;
  always @(posedge pl_clk) begin
    if (bus.pl_we != '0) begin
      wtmp = mem.exists(bus.pl_addr) ? mem[bus.pl_addr] : '0;
      for (int i = 0; i < 4; i++)
        if (bus.pl_we[i]) wtmp[8*i +: 8] = bus.pl_din[8*i +: 8];
      mem[bus.pl_addr] = wtmp;
    end
    bus.pl_dout <= mem.exists(bus.pl_addr) ? mem[bus.pl_addr] : '0;
  end

  // Reference model: every byte's LSB is replaced by one message bit.
  function automatic logic [31:0] model_embed(input logic [31:0] w, input logic [3:0] nib);
    logic [31:0] spread;
    spread = {7'b0, nib[3], 7'b0, nib[2], 7'b0, nib[1], 7'b0, nib[0]};
    return (w & 32'hFEFE_FEFE) | spread;
  endfunction

  logic [7:0]  msg_src [256];
  int          msg_idx = 0;
  logic [31:0] exp_addr [64];
  logic [31:0] exp_data [64];
  logic [31:0] wr_log   [64];
  int          exp_nw = 0;
  int          wr_idx = 0, hs_cnt = 0, cyc = 0, done_cyc = 0, first_wr_cyc = 0;
  int          busy_cnt = 0, mode_cnt = 0;
  logic        job_active = 1'b0;
  logic        ab_at_done = 1'b0;

  // Per-cycle compare against the expected write list.
  always @(negedge pl_clk) begin
    if (pl_rst_n) begin
      check("ready_implies_valid", 32'(bus.msg_ready & ~bus.msg_valid), 32'd0);
      if (bus.msg_ready && bus.msg_valid) begin
        hs_cnt++;
        msg_idx = (msg_idx + 1) % 256;
      end
      if (job_active) begin
        cyc++;
        busy_cnt += int'(busy);
        mode_cnt += int'(bus.bram_mode);
        if (done && done_cyc == 0) begin
          done_cyc   = cyc;
          ab_at_done = aborted;
        end
        if (bus.pl_we != '0) begin
          if (first_wr_cyc == 0) first_wr_cyc = cyc;
          check("we_mask", 32'(bus.pl_we), 32'hF);
          check("write_in_range", 32'(wr_idx < exp_nw), 32'd1);
          if (wr_idx < exp_nw) begin
            check("write_addr", bus.pl_addr, exp_addr[wr_idx]);
            check("write_data", bus.pl_din, exp_data[wr_idx]);
          end
          if (wr_idx < 64) wr_log[wr_idx] = bus.pl_addr;
          wr_idx++;
        end
      end else begin
        check("idle_bus", 32'({bus.bram_mode, bus.pl_we, busy}), 32'd0);
      end
    end
  end

  // vmode 0: msg_valid always high; 1: random. abort_cyc counts cycles from ACQ=1.
  task automatic run_job(input logic [31:0] base, input int n, input bit fill,
                         input int abort_cyc, input int vmode,
                         input int stall_at, input int stall_len, input bit timed);
    int          idx0, nw, exp_done, c, k, ph;
    bit          in_stall;
    logic [31:0] orig [64];
    logic [31:0] a;
    logic [7:0]  b;
    idx0 = msg_idx;
    for (int j = 0; j < n; j++) begin
      a = base + 32'(4 * j);
      if (fill) mem[a] = $urandom;
      orig[j]     = mem.exists(a) ? mem[a] : '0;
      b           = msg_src[(idx0 + j / 2) % 256];
      exp_addr[j] = a;
      exp_data[j] = model_embed(orig[j], (j % 2 == 1) ? b[7:4] : b[3:0]);
    end
    if (abort_cyc == 0) nw = n;
    else if (abort_cyc == 1) nw = 0;
    else begin
      k  = (abort_cyc - 2) / 4;
      ph = (abort_cyc - 2) % 4;
      nw = (ph == 3) ? k + 1 : k;
      if (nw > n) nw = n;
    end
    exp_done = (abort_cyc == 0) ? 3 + 4 * n + stall_len : abort_cyc + 2;
    exp_nw = nw; wr_idx = 0; hs_cnt = 0; cyc = 0; done_cyc = 0; first_wr_cyc = 0;
    busy_cnt = 0; mode_cnt = 0;

    @(posedge pl_clk); #1;
    base_addr = base; num_words = 32'(n); start = 1'b1;
    @(posedge pl_clk); #1;
    start = 1'b0; job_active = 1'b1; c = 1;
    while (done_cyc == 0 && c < 4000) begin
      abort    = (c == abort_cyc);
      in_stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
      bus.msg_valid = in_stall ? 1'b0 : ((vmode == 0) ? 1'b1 : ($urandom_range(2) != 0));
      bus.msg_data  = msg_src[msg_idx];
      if (in_stall) begin
        #2;
        check("stall_addr", bus.pl_addr, exp_addr[0]);
        check("stall_we", 32'(bus.pl_we), 32'd0);
        check("stall_ready", 32'(bus.msg_ready), 32'd0);
      end
      @(posedge pl_clk); #1;
      c++;
    end
    abort = 1'b0;
    bus.msg_valid = 1'b0;
    repeat (2) @(posedge pl_clk);
    #1;
    job_active = 1'b0;

    check("done_seen", 32'(done_cyc != 0), 32'd1);
    if (timed) check("done_cycle", done_cyc, exp_done);
    check("busy_cycles", busy_cnt, done_cyc - 1);
    check("bram_mode_cycles", mode_cnt, done_cyc - 1);
    check("write_count", wr_idx, nw);
    check("words_done", words_done, nw);
    check("aborted_at_done", 32'(ab_at_done), 32'(abort_cyc != 0));
    check("aborted_held", 32'(aborted), 32'(abort_cyc != 0));
    check("msg_bytes", hs_cnt, (nw + 1) / 2);
    for (int j = 0; j < n; j++)
      check("mem_word", mem[exp_addr[j]], (j < nw) ? exp_data[j] : orig[j]);
  endtask

  initial begin
    int n, ac;
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    for (int i = 0; i < 256; i++) msg_src[i] = 8'($urandom);

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_words_done", words_done, 32'd0);
    check("rst_bram_mode", 32'(bus.bram_mode), 32'd0);
    check("rst_we", 32'(bus.pl_we), 32'd0);
    check("rst_addr", bus.pl_addr, 32'd0);
    check("rst_din", bus.pl_din, 32'd0);
    check("rst_ready", 32'(bus.msg_ready), 32'd0);
    repeat (2) @(posedge pl_clk);
    #2 pl_rst_n = 1'b1;

    // Basic embed
    mem[32'h10] = 32'h1122_3344;
    mem[32'h14] = 32'hAABB_CCDD;
    msg_src[msg_idx] = 8'hA5;
    run_job(32'h10, 2, 1'b0, 0, 0, 0, 0, 1'b1);
    check("basic_mem0", mem[32'h10], 32'h1023_3245);
    check("basic_mem1", mem[32'h14], 32'hABBA_CDDC);
    check("basic_done_cycle", done_cyc, 11);
    check("basic_words_done", words_done, 32'd2);
    check("basic_msg_bytes", hs_cnt, 1);

    // Zero length
    run_job(32'h40, 0, 1'b1, 0, 0, 0, 0, 1'b1);
    check("zero_done_cycle", done_cyc, 3);
    check("zero_mode_cycles", mode_cnt, 2);

    // Message stall in MOD of word 0
    run_job(32'h10, 2, 1'b1, 0, 0, 4, 5, 1'b1);
    check("stall_first_write", first_wr_cyc, 10);

    // Odd count with address wrap
    run_job(32'hFFFF_FFFC, 3, 1'b1, 0, 0, 0, 0, 1'b1);
    check("wrap_addr0", wr_log[0], 32'hFFFF_FFFC);
    check("wrap_addr1", wr_log[1], 32'h0000_0000);
    check("wrap_addr2", wr_log[2], 32'h0000_0004);
    check("wrap_msg_bytes", hs_cnt, 2);

    // Abort in WR of word 1 of 4, then in WAIT of word 2
    run_job(32'h200, 4, 1'b1, 9, 0, 0, 0, 1'b1);
    check("abort_wr_words", words_done, 32'd2);
    check("abort_wr_flag", 32'(aborted), 32'd1);
    run_job(32'h300, 4, 1'b1, 11, 0, 0, 0, 1'b1);
    check("abort_wait_writes", wr_idx, 2);

    // Reset asserted in WAIT of word 0
    exp_nw = 0; wr_idx = 0; hs_cnt = 0; cyc = 0; done_cyc = 0;
    @(posedge pl_clk); #1;
    base_addr = 32'h100; num_words = 32'd4; start = 1'b1; bus.msg_valid = 1'b1;
    @(posedge pl_clk); #1;
    start = 1'b0; job_active = 1'b1;
    repeat (2) @(posedge pl_clk);
    #2;
    check("pre_reset_mode", 32'(bus.bram_mode), 32'd1);
    pl_rst_n = 1'b0;
    #1;
    check("reset_mode", 32'(bus.bram_mode), 32'd0);
    check("reset_we", 32'(bus.pl_we), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge pl_clk);
    #2 pl_rst_n = 1'b1;
    repeat (4) @(posedge pl_clk);
    #1;
    check("reset_no_done", done_cyc, 0);
    check("reset_no_write", wr_idx, 0);
    check("reset_words_done", words_done, 32'd0);
    job_active = 1'b0; bus.msg_valid = 1'b0;
    run_job(32'h400, 3, 1'b1, 0, 0, 0, 0, 1'b1);

    // Randomized jobs with random msg_valid gaps
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(12);
      run_job($urandom & 32'hFFFF_FFFC, n, 1'b1, 0, 1, 0, 0, 1'b0);
    end
    // Randomized aborts (not in MOD, where a byte may be taken and dropped)
    for (int t = 0; t < 6; t++) begin
      n  = 1 + $urandom_range(7);
      ac = 1 + $urandom_range(4 * n);
      if (ac >= 2 && (ac - 2) % 4 == 2) ac++;
      run_job($urandom & 32'hFFFF_FFFC, n, 1'b1, ac, 0, 0, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
